// File: rtl/vga_sync_module.sv
// 640x480@60 raster timing generator: free-running pixel/line counters decoded
// into registered, mutually aligned sync, visible-area, coordinate and frame-start outputs.
module vga_sync_module #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_h_cnt_p0;
  logic [9:0] r_v_cnt_p0;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_vis;
  logic       w_fs;

  logic       r_hsync_p1;
  logic       r_vsync_p1;
  logic       r_vis_p1;
  logic       r_fs_p1;
  logic [9:0] r_x_p1;
  logic [9:0] r_y_p1;

  assign w_h_wrap = (r_h_cnt_p0 == H_LAST);
  assign w_v_wrap = (r_v_cnt_p0 == V_LAST);

  // Stage p0: raster position counters
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt_p0 <= '0;
      r_v_cnt_p0 <= '0;
    end else begin
      if (w_h_wrap) begin
        r_h_cnt_p0 <= '0;
        r_v_cnt_p0 <= w_v_wrap ? 10'd0 : r_v_cnt_p0 + 10'd1;
      end else begin
        r_h_cnt_p0 <= r_h_cnt_p0 + 10'd1;
      end
    end
  end

  assign w_hsync_n = !((r_h_cnt_p0 >= HS_START) && (r_h_cnt_p0 < HS_END));
  assign w_vsync_n = !((r_v_cnt_p0 >= VS_START) && (r_v_cnt_p0 < VS_END));
  assign w_vis     = (r_h_cnt_p0 < H_VIS) && (r_v_cnt_p0 < V_VIS);
  assign w_fs      = (r_h_cnt_p0 == 10'd0) && (r_v_cnt_p0 == 10'd0);

  // Stage p1: registered decode, all outputs describe the same (x, y)
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_p1 <= 1'b1;
      r_vsync_p1 <= 1'b1;
      r_vis_p1   <= 1'b0;
      r_fs_p1    <= 1'b0;
      r_x_p1     <= '0;
      r_y_p1     <= '0;
    end else begin
      r_hsync_p1 <= w_hsync_n;
      r_vsync_p1 <= w_vsync_n;
      r_vis_p1   <= w_vis;
      r_fs_p1    <= w_fs;
      r_x_p1     <= r_h_cnt_p0;
      r_y_p1     <= r_v_cnt_p0;
    end
  end

  assign hsync       = r_hsync_p1;
  assign vsync       = r_vsync_p1;
  assign video_on    = r_vis_p1;
  assign frame_start = r_fs_p1;
  assign pixel_x     = r_x_p1;
  assign pixel_y     = r_y_p1;

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench: full-size instance for reset and line timing, a reduced-geometry
// instance (30 x 19 raster, 570-cycle frame) for frame-level, wrap and mid-frame reset behaviour.
module tb_vga_sync_module;

  logic clk = 1'b0;
  logic rst_n;
  always #20 clk = ~clk;

  logic       d_hs, d_vs, d_vid, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vid, s_fs;
  logic [9:0] s_x, s_y;

  int checks   = 0;
  int failures = 0;

  vga_sync_module u_full (
    .clk_25MHz  (clk),
    .rst_n      (rst_n),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .video_on   (d_vid),
    .pixel_x    (d_x),
    .pixel_y    (d_y),
    .frame_start(d_fs)
  );

  // Small raster: H 16+4+6+4 = 30 (hsync low x=20..25), V 12+2+2+3 = 19 (vsync low y=14..15)
  vga_sync_module #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (
    .clk_25MHz  (clk),
    .rst_n      (rst_n),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .video_on   (s_vid),
    .pixel_x    (s_x),
    .pixel_y    (s_y),
    .frame_start(s_fs)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({d_hs, d_vs, d_vid, d_fs, d_x, d_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL reset_full got hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d want hs=1 vs=1 vid=0 fs=0 x=0 y=0",
               d_hs, d_vs, d_vid, d_fs, d_x, d_y);
    end
    checks++;
    if ({s_hs, s_vs, s_vid, s_fs, s_x, s_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL reset_small got hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d want hs=1 vs=1 vid=0 fs=0 x=0 y=0",
               s_hs, s_vs, s_vid, s_fs, s_x, s_y);
    end
  endtask

  task automatic test_first_edge;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_hs, d_vs, d_vid, d_fs, d_x, d_y} !== {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL first_edge_full got hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d want hs=1 vs=1 vid=1 fs=1 x=0 y=0",
               d_hs, d_vs, d_vid, d_fs, d_x, d_y);
    end
    checks++;
    if ({s_hs, s_vs, s_vid, s_fs, s_x, s_y} !== {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL first_edge_small got hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d want hs=1 vs=1 vid=1 fs=1 x=0 y=0",
               s_hs, s_vs, s_vid, s_fs, s_x, s_y);
    end
  endtask

  // Full-size instance starting at (0,0): two lines plus the first sample of the third.
  task automatic test_line_timing;
    int ex, ey, bad, first_bad;
    int hs_low, vid_hi, hs_fall, hs_rise, vid_fall;
    logic exp_hs, exp_vid, exp_fs, prev_hs, prev_vid;
    bad = 0; first_bad = -1; hs_low = 0; vid_hi = 0;
    hs_fall = -1; hs_rise = -1; vid_fall = -1;
    prev_hs = 1'b1; prev_vid = 1'b1;
    for (int i = 0; i <= 1600; i++) begin
      ex = i % 800;
      ey = i / 800;
      exp_hs  = !(ex >= 656 && ex < 752);
      exp_vid = (ex < 640);
      exp_fs  = (ex == 0 && ey == 0);
      if (d_x !== 10'(ex) || d_y !== 10'(ey) || d_hs !== exp_hs || d_vid !== exp_vid ||
          d_fs !== exp_fs || d_vs !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i < 800) begin
        if (!d_hs) hs_low++;
        if (d_vid) vid_hi++;
        if (prev_hs && !d_hs) hs_fall = int'(d_x);
        if (!prev_hs && d_hs) hs_rise = int'(d_x);
        if (prev_vid && !d_vid) vid_fall = int'(d_x);
      end
      prev_hs  = d_hs;
      prev_vid = d_vid;
      if (i < 1600) @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL line_sequence got %0d bad cycles (first at cycle %0d) want 0", bad, first_bad);
    end
    checks++;
    if (hs_low !== 96) begin failures++; $display("FAIL hsync_width got %0d want 96", hs_low); end
    checks++;
    if (vid_hi !== 640) begin failures++; $display("FAIL video_width got %0d want 640", vid_hi); end
    checks++;
    if (hs_fall !== 656) begin failures++; $display("FAIL hsync_fall_x got %0d want 656", hs_fall); end
    checks++;
    if (hs_rise !== 752) begin failures++; $display("FAIL hsync_rise_x got %0d want 752", hs_rise); end
    checks++;
    if (vid_fall !== 640) begin failures++; $display("FAIL video_fall_x got %0d want 640", vid_fall); end
  endtask

  task automatic wait_small_fs(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (s_fs === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Small instance: one complete frame from frame_start to the next one.
  task automatic test_frame;
    bit ok;
    int ex, ey, bad, first_bad, vs_low, vid_hi, fs_cnt, vid_late;
    int vs_fall_x, vs_fall_y, vs_rise_x, vs_rise_y;
    logic exp_hs, exp_vs, exp_vid, exp_fs, prev_vs;
    wait_small_fs(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_sync_wait got no frame_start want pulse within 2000 cycles");
      return;
    end
    bad = 0; first_bad = -1; vs_low = 0; vid_hi = 0; fs_cnt = 0; vid_late = 0;
    vs_fall_x = -1; vs_fall_y = -1; vs_rise_x = -1; vs_rise_y = -1;
    prev_vs = 1'b1;
    for (int i = 0; i <= 570; i++) begin
      ex = i % 30;
      ey = (i / 30) % 19;
      exp_hs  = !(ex >= 20 && ex < 26);
      exp_vs  = !(ey >= 14 && ey < 16);
      exp_vid = (ex < 16) && (ey < 12);
      exp_fs  = (ex == 0) && (ey == 0);
      if (s_x !== 10'(ex) || s_y !== 10'(ey) || s_hs !== exp_hs || s_vs !== exp_vs ||
          s_vid !== exp_vid || s_fs !== exp_fs) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i < 570) begin
        if (!s_vs) vs_low++;
        if (s_vid) vid_hi++;
        if (s_fs) fs_cnt++;
        if (s_vid && s_y >= 10'd12) vid_late++;
        if (prev_vs && !s_vs) begin vs_fall_x = int'(s_x); vs_fall_y = int'(s_y); end
        if (!prev_vs && s_vs) begin vs_rise_x = int'(s_x); vs_rise_y = int'(s_y); end
      end
      if (i == 569) begin
        checks++;
        if ({s_x, s_y, s_fs, s_vid, s_hs, s_vs} !== {10'd29, 10'd18, 1'b0, 1'b0, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL wrap_last got x=%0d y=%0d fs=%b vid=%b hs=%b vs=%b want x=29 y=18 fs=0 vid=0 hs=1 vs=1",
                   s_x, s_y, s_fs, s_vid, s_hs, s_vs);
        end
      end
      if (i == 570) begin
        checks++;
        if ({s_x, s_y, s_fs, s_vid, s_hs, s_vs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL wrap_next got x=%0d y=%0d fs=%b vid=%b hs=%b vs=%b want x=0 y=0 fs=1 vid=1 hs=1 vs=1",
                   s_x, s_y, s_fs, s_vid, s_hs, s_vs);
        end
      end
      prev_vs = s_vs;
      if (i < 570) @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL frame_sequence got %0d bad cycles (first at cycle %0d) want 0", bad, first_bad);
    end
    checks++;
    if (vs_low !== 60) begin failures++; $display("FAIL vsync_width got %0d want 60", vs_low); end
    checks++;
    if (vid_hi !== 192) begin failures++; $display("FAIL frame_video_cycles got %0d want 192", vid_hi); end
    checks++;
    if (fs_cnt !== 1) begin failures++; $display("FAIL frame_start_count got %0d want 1", fs_cnt); end
    checks++;
    if (vid_late !== 0) begin failures++; $display("FAIL video_below_visible got %0d want 0", vid_late); end
    checks++;
    if (vs_fall_x !== 0 || vs_fall_y !== 14 || vs_rise_x !== 0 || vs_rise_y !== 16) begin
      failures++;
      $display("FAIL vsync_edges got fall=(%0d,%0d) rise=(%0d,%0d) want fall=(0,14) rise=(0,16)",
               vs_fall_x, vs_fall_y, vs_rise_x, vs_rise_y);
    end
  endtask

  task automatic count_small_period(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_fs !== 1'b1 && n < 2000);
    checks++;
    if (n !== 570) begin failures++; $display("FAIL %s got %0d cycles want 570", name, n); end
  endtask

  task automatic test_mid_frame_reset;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (s_y === 10'd7 && s_x === 10'd10) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midreset_wait got no (10,7) want position within 2000 cycles");
      return;
    end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_hs, s_vs, s_vid, s_fs, s_x, s_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL async_reset_small got hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d want hs=1 vs=1 vid=0 fs=0 x=0 y=0",
               s_hs, s_vs, s_vid, s_fs, s_x, s_y);
    end
    checks++;
    if ({d_hs, d_vs, d_vid, d_fs, d_x, d_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL async_reset_full got hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d want hs=1 vs=1 vid=0 fs=0 x=0 y=0",
               d_hs, d_vs, d_vid, d_fs, d_x, d_y);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_x, s_y, s_fs, s_vid} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL restart_small got x=%0d y=%0d fs=%b vid=%b want x=0 y=0 fs=1 vid=1", s_x, s_y, s_fs, s_vid);
    end
    count_small_period("restart_period");
    checks++;
    if ({d_x, d_y, d_vid, d_fs} !== {10'd570, 10'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL restart_full got x=%0d y=%0d vid=%b fs=%b want x=570 y=0 vid=1 fs=0", d_x, d_y, d_vid, d_fs);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_line_timing();
    test_frame();
    count_small_period("frame_period");
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
